// File: rtl/countdown_ctrl_if.sv
// Control/status bundle between software-visible control bits and countdown_ctrl.
interface countdown_ctrl_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] load_val;
   logic             pause;
   logic             abort;
   logic             auto_reload;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   // Software-side driver of the control bits
   modport master (
      output start, load_val, pause, abort, auto_reload,
      input  count, busy, done
   );

   // Controller side
   modport slave (
      input  start, load_val, pause, abort, auto_reload,
      output count, busy, done
   );
endinterface

// File: rtl/countdown_ctrl.sv
// Sequencing controller for a down-counter: load, prescaled decrement,
// pause/resume, abort, one-cycle done pulse and optional auto-reload.
module countdown_ctrl #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 1
) (
   input logic           clk,
   input logic           reset,
   countdown_ctrl_if.slave bus
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] TICK_MAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] reload_q;
   logic [PW-1:0]    presc;

   // Status flags decode the state register only, so inputs cannot glitch them
   assign bus.count = count_q;
   assign bus.busy  = (state == RUN) || (state == HOLD);
   assign bus.done  = (state == DONE);

   // State, count, reload value and prescaler update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         presc    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  count_q  <= bus.load_val;
                  reload_q <= bus.load_val;
                  presc    <= '0;
                  state    <= (bus.load_val != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (bus.abort) begin
                  count_q <= '0;
                  presc   <= '0;
                  state   <= IDLE;
               end else if (bus.pause) begin
                  state <= HOLD;
               end else if (presc == TICK_MAX) begin
                  presc <= '0;
                  // Terminal step goes to DONE rather than wrapping below zero
                  if (count_q == WIDTH'(1)) begin
                     count_q <= '0;
                     state   <= DONE;
                  end else begin
                     count_q <= WIDTH'(count_q - WIDTH'(1));
                  end
               end else begin
                  presc <= PW'(presc + PW'(1));
               end
            end
            HOLD: begin
               if (bus.abort) begin
                  count_q <= '0;
                  presc   <= '0;
                  state   <= IDLE;
               end else if (!bus.pause) begin
                  state <= RUN;
               end
            end
            DONE: begin
               if (bus.auto_reload && (reload_q != '0)) begin
                  count_q <= reload_q;
                  presc   <= '0;
                  state   <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
